// File: rtl/rv32im_pkg.sv
// Shared definitions for the RV32IM load/store path: funct3 encodings,
// memory word-size encodings, LSU controller states, and a legality helper.
package rv32im_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RECOVER,
    ST_DONE
  } lsu_state_e;

  // Stores accept only B/H/W; loads additionally accept BU/HU.
  function automatic logic legal_access(input logic write, input logic [2:0] funct3);
    logic ok;
    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    if (!write) ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/rv32im_lsu_if.sv
// Request interface between the LSU (master) and rv32im_memory (slave).
// master drives clear / data_ready / addr / data / word_size / write;
// slave returns the raw 32-bit word, busy and the sticky error flag.
interface rv32im_lsu_if;
  logic        mem_clear_o;
  logic        mem_data_ready_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [1:0]  mem_word_size_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;
  logic        mem_busy_i;
  logic        mem_err_i;

  modport master (
    output mem_clear_o, mem_data_ready_o, mem_addr_o, mem_data_o,
           mem_word_size_o, mem_write_o,
    input  mem_data_i, mem_busy_i, mem_err_i
  );

  modport slave (
    input  mem_clear_o, mem_data_ready_o, mem_addr_o, mem_data_o,
           mem_word_size_o, mem_write_o,
    output mem_data_i, mem_busy_i, mem_err_i
  );
endinterface

// File: rtl/rv32im_load_align.sv
// Combinational load datapath.
//   raw_i       : raw 32-bit word from memory (not lane shifted)
//   lane_i      : byte offset of the current sub-access
//   size_i      : size of the current sub-access
//   funct3_i    : original load funct3 (selects sign/zero extension)
//   buf_i       : assembled little-endian load buffer
//   lane_data_o : current sub-access data, right-justified and zero-filled
//   result_o    : buf_i extended per funct3_i
module rv32im_load_align
  import rv32im_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  lane_i,
  input  mem_size_e   size_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] buf_i,
  output logic [31:0] lane_data_o,
  output logic [31:0] result_o
);

  logic [7:0] byte_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
  end

  always_comb begin
    lane_data_o = raw_i;
    case (size_i)
      SZ_BYTE: lane_data_o = {24'h0, byte_sel};
      SZ_HALF: lane_data_o = lane_i[1] ? {16'h0, raw_i[31:16]} : {16'h0, raw_i[15:0]};
      default: lane_data_o = raw_i;
    endcase
  end

  always_comb begin
    result_o = buf_i;
    case (funct3_i)
      F3_B:    result_o = {{24{buf_i[7]}}, buf_i[7:0]};
      F3_H:    result_o = {{16{buf_i[15]}}, buf_i[15:0]};
      F3_BU:   result_o = {24'h0, buf_i[7:0]};
      F3_HU:   result_o = {16'h0, buf_i[15:0]};
      default: result_o = buf_i;
    endcase
  end

endmodule

// File: rtl/rv32im_lsu.sv
// RV32 load/store unit between execute and rv32im_memory.
//   clk_i, clear_i          : clock, synchronous active-high clear
//   req_i / ready_o         : request handshake from execute
//   write_i, funct3_i       : access kind
//   addr_i, wdata_i         : byte address, store data
//   done_o, rdata_o, err_o  : one-cycle completion with extended load data / error
//   mem                     : request port to rv32im_memory
// Misaligned half/word accesses are split into sequential byte accesses so
// the memory only ever sees naturally aligned requests.
module rv32im_lsu
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN = 32
)
(
  input  logic            clk_i,
  input  logic            clear_i,
  input  logic            req_i,
  output logic            ready_o,
  input  logic            write_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  rv32im_lsu_if.master    mem
);

  lsu_state_e state_q, state_d;

  logic            write_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] base_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] buf_q;
  logic [1:0]      idx_q;
  logic [1:0]      last_q;
  logic            split_q;
  mem_size_e       size_q;
  logic            err_q;

  logic            legal;
  mem_size_e       size_d;
  logic [1:0]      last_d;
  logic            split_d;

  logic [XLEN-1:0] sub_addr;
  logic [7:0]      store_byte;
  logic [31:0]     lane_data;
  logic [31:0]     load_result;
  logic            sub_ok;

  // Sub-access plan for the incoming request.
  always_comb begin
    legal   = legal_access(write_i, funct3_i);
    size_d  = SZ_BYTE;
    last_d  = 2'd0;
    split_d = 1'b0;
    case (funct3_i[1:0])
      2'b01: begin
        if (addr_i[0]) begin
          split_d = 1'b1;
          last_d  = 2'd1;
        end else begin
          size_d  = SZ_HALF;
        end
      end
      2'b10: begin
        if (addr_i[1:0] != 2'b00) begin
          split_d = 1'b1;
          last_d  = 2'd3;
        end else begin
          size_d  = SZ_WORD;
        end
      end
      default: ;
    endcase
  end

  assign sub_addr = base_q + {{(XLEN-2){1'b0}}, idx_q};
  assign sub_ok   = !mem.mem_busy_i && !mem.mem_err_i;

  always_comb begin
    case (idx_q)
      2'd0:    store_byte = wdata_q[7:0];
      2'd1:    store_byte = wdata_q[15:8];
      2'd2:    store_byte = wdata_q[23:16];
      default: store_byte = wdata_q[31:24];
    endcase
  end

  rv32im_load_align u_align (
    .raw_i       (mem.mem_data_i),
    .lane_i      (sub_addr[1:0]),
    .size_i      (size_q),
    .funct3_i    (funct3_q),
    .buf_i       (buf_q),
    .lane_data_o (lane_data),
    .result_o    (load_result)
  );

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      split_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            write_q  <= write_i;
            funct3_q <= funct3_i;
            base_q   <= addr_i;
            wdata_q  <= wdata_i;
            buf_q    <= '0;
            idx_q    <= '0;
            last_q   <= last_d;
            split_q  <= split_d;
            size_q   <= size_d;
            err_q    <= !legal;
          end
        end
        ST_WAIT: begin
          if (sub_ok) begin
            if (!write_q) begin
              // Split accesses assemble bytes little-endian at the sub-access index.
              if (split_q) buf_q[{idx_q, 3'b000} +: 8] <= lane_data[7:0];
              else         buf_q <= lane_data;
            end
            idx_q <= idx_q + 2'd1;
          end
        end
        ST_RECOVER: err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_i) state_d = legal ? ST_ISSUE : ST_DONE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (!mem.mem_busy_i) begin
          if (mem.mem_err_i)        state_d = ST_RECOVER;
          else if (idx_q == last_q) state_d = ST_DONE;
          else                      state_d = ST_ISSUE;
        end
      end
      ST_RECOVER: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o              = (state_q == ST_IDLE);
    done_o               = (state_q == ST_DONE);
    err_o                = (state_q == ST_DONE) && err_q;
    rdata_o              = load_result;
    mem.mem_clear_o      = clear_i || (state_q == ST_RECOVER);
    mem.mem_data_ready_o = (state_q == ST_ISSUE);
    mem.mem_addr_o       = '0;
    mem.mem_data_o       = '0;
    mem.mem_word_size_o  = SZ_BYTE;
    mem.mem_write_o      = 1'b0;
    // Request fields are held stable for the whole ISSUE/WAIT span.
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      mem.mem_addr_o      = sub_addr;
      mem.mem_word_size_o = size_q;
      mem.mem_write_o     = write_q;
      case (size_q)
        SZ_BYTE: mem.mem_data_o = {4{store_byte}};
        SZ_HALF: mem.mem_data_o = {2{wdata_q[15:0]}};
        default: mem.mem_data_o = wdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_lsu.sv
// Self-checking bench for rv32im_lsu: directed cases plus randomized
// loads/stores against a byte-array reference model.
module tb_rv32im_lsu;
  import rv32im_pkg::*;

  logic        clk = 1'b0;
  logic        clear, req, write, ready, done, err;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  rv32im_lsu_if mem ();

  rv32im_lsu #(.XLEN(32)) dut (
    .clk_i(clk), .clear_i(clear), .req_i(req), .ready_o(ready),
    .write_i(write), .funct3_i(f3), .addr_i(addr), .wdata_i(wdata),
    .done_o(done), .rdata_o(rdata), .err_o(err), .mem(mem)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory slave model ----------------
  typedef struct {
    logic [31:0] a;
    logic [1:0]  sz;
    logic        wr;
    logic [31:0] d;
  } acc_t;

  acc_t        acc_q[$];
  logic [7:0]  slave_mem [0:4095];
  logic [7:0]  ref_mem   [0:4095];
  logic        s_busy = 1'b0, s_err = 1'b0, s_fail = 1'b0;
  logic [31:0] s_rdata = '0, s_addr = '0, s_data = '0;
  logic [1:0]  s_size = '0;
  logic        s_write = 1'b0;
  int          s_wcnt = 0;
  int          ws_min = 0, ws_max = 0;
  int          fail_at = -1;

  assign mem.mem_data_i = s_rdata;
  assign mem.mem_busy_i = s_busy;
  assign mem.mem_err_i  = s_err;

  always @(posedge clk) begin
    if (mem.mem_clear_o) begin
      s_busy <= 1'b0;
      s_err  <= 1'b0;
      s_wcnt <= 0;
    end else if (!s_busy && mem.mem_data_ready_o) begin
      s_fail  <= (acc_q.size() == fail_at);
      acc_q.push_back('{mem.mem_addr_o, mem.mem_word_size_o, mem.mem_write_o, mem.mem_data_o});
      s_busy  <= 1'b1;
      s_wcnt  <= $urandom_range(ws_max, ws_min);
      s_addr  <= mem.mem_addr_o;
      s_data  <= mem.mem_data_o;
      s_size  <= mem.mem_word_size_o;
      s_write <= mem.mem_write_o;
    end else if (s_busy) begin
      if (s_wcnt != 0) s_wcnt <= s_wcnt - 1;
      else begin
        logic [3:0] en;
        s_busy <= 1'b0;
        case (s_size)
          2'd0:    en = 4'b0001 << s_addr[1:0];
          2'd1:    en = s_addr[1] ? 4'b1100 : 4'b0011;
          default: en = 4'b1111;
        endcase
        if (s_fail) s_err <= 1'b1;
        else if (s_write)
          for (int b = 0; b < 4; b++)
            if (en[b]) slave_mem[{s_addr[11:2], b[1:0]}] <= s_data[8*b +: 8];
        s_rdata <= {slave_mem[{s_addr[11:2], 2'd3}], slave_mem[{s_addr[11:2], 2'd2}],
                    slave_mem[{s_addr[11:2], 2'd1}], slave_mem[{s_addr[11:2], 2'd0}]};
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic int subs_of(input logic [2:0] f, input logic [31:0] a);
    int nb = nbytes_of(f);
    if (nb == 1 || (a % nb) == 0) return 1;
    return nb;
  endfunction

  function automatic bit is_legal(input logic w, input logic [2:0] f);
    if (w) return (f == 3'd0 || f == 3'd1 || f == 3'd2);
    return (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
  endfunction

  // Computes the expected outcome and applies store effects to ref_mem.
  task automatic model(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input int rel_fail,
                       output logic [31:0] e_rdata, output logic e_err,
                       output int e_nacc, output int e_lat);
    int nb, k, nwr;
    logic [31:0] v;
    e_rdata = '0;
    if (!is_legal(w, f)) begin
      e_err = 1'b1; e_nacc = 0; e_lat = 1;
      return;
    end
    nb = nbytes_of(f);
    k  = subs_of(f, a);
    if (rel_fail >= 0 && rel_fail < k) begin
      e_err  = 1'b1;
      e_nacc = rel_fail + 1;
      e_lat  = 5 + 3 * rel_fail;
      nwr    = (k == 1) ? 0 : rel_fail;
    end else begin
      e_err  = 1'b0;
      e_nacc = k;
      e_lat  = 1 + 3 * k;
      nwr    = nb;
    end
    if (w) begin
      for (int i = 0; i < nwr; i++) ref_mem[(a + i) & 32'hFFF] = d[8*i +: 8];
    end else if (!e_err) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[(a + i) & 32'hFFF];
      if (f == 3'd0)      v = {{24{v[7]}}, v[7:0]};
      else if (f == 3'd1) v = {{16{v[15]}}, v[15:0]};
      e_rdata = v;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    slave_mem[a & 32'hFFF] = b;
    ref_mem[a & 32'hFFF]   = b;
  endtask

  int base_idx;

  task automatic run_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input int rel_fail,
                        output logic [31:0] g_rdata, output logic g_err,
                        output int lat, output int nacc, output int nclr);
    bit seen;
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    base_idx = acc_q.size();
    fail_at  = (rel_fail < 0) ? -1 : base_idx + rel_fail;
    req = 1'b1; write = w; f3 = f; addr = a; wdata = d;
    lat = 0; nclr = 0; seen = 0; g_rdata = '0; g_err = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      // Scramble request inputs: the unit must have latched them at accept.
      req = 1'b0; write = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (mem.mem_clear_o) nclr++;
      if (done) begin seen = 1; g_rdata = rdata; g_err = err; end
    end
    check_val("done_seen", 32'(seen), 32'd1);
    nacc = acc_q.size() - base_idx;
    @(negedge clk);
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("ready_after", 32'(ready), 32'd1);
    fail_at = -1;
  endtask

  logic [31:0] g_rd, e_rd;
  logic        g_er, e_er;
  int          lat, nacc, nclr, e_nacc, e_lat;

  initial begin
    clear = 1'b1; req = 1'b0; write = 1'b0; f3 = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      slave_mem[i] = b;
      ref_mem[i]   = b;
    end
    repeat (3) @(negedge clk);
    check_val("rst_mem_clear", 32'(mem.mem_clear_o), 32'd1);
    check_val("rst_ready", 32'(ready), 32'd1);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_dready", 32'(mem.mem_data_ready_o), 32'd0);
    check_val("rst_write", 32'(mem.mem_write_o), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    clear = 1'b0;
    @(negedge clk);
    check_val("post_rst_mem_clear", 32'(mem.mem_clear_o), 32'd0);

    // LW aligned
    poke(32'h100, 8'hEF); poke(32'h101, 8'hBE); poke(32'h102, 8'hAD); poke(32'h103, 8'hDE);
    run_op(1'b0, 3'd2, 32'h100, 32'h0, -1, g_rd, g_er, lat, nacc, nclr);
    check_val("lw_rdata", g_rd, 32'hDEADBEEF);
    check_val("lw_err", 32'(g_er), 32'd0);
    check_val("lw_lat", 32'(lat), 32'd4);
    check_val("lw_nacc", 32'(nacc), 32'd1);
    check_val("lw_size", 32'(acc_q[base_idx].sz), 32'd2);

    // LB / LBU sign handling
    poke(32'h100, 8'h00); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h80);
    run_op(1'b0, 3'd0, 32'h103, 32'h0, -1, g_rd, g_er, lat, nacc, nclr);
    check_val("lb_rdata", g_rd, 32'hFFFFFF80);
    run_op(1'b0, 3'd4, 32'h103, 32'h0, -1, g_rd, g_er, lat, nacc, nclr);
    check_val("lbu_rdata", g_rd, 32'h00000080);

    // SH aligned
    model(1'b1, 3'd1, 32'h202, 32'h0000ABCD, -1, e_rd, e_er, e_nacc, e_lat);
    run_op(1'b1, 3'd1, 32'h202, 32'h0000ABCD, -1, g_rd, g_er, lat, nacc, nclr);
    check_val("sh_nacc", 32'(nacc), 32'd1);
    check_val("sh_data", acc_q[base_idx].d, 32'hABCDABCD);
    check_val("sh_size", 32'(acc_q[base_idx].sz), 32'd1);
    check_val("sh_addr", acc_q[base_idx].a, 32'h202);

    // LW misaligned across a word boundary
    poke(32'h0FF, 8'h11); poke(32'h100, 8'h22); poke(32'h101, 8'h33); poke(32'h102, 8'h44);
    run_op(1'b0, 3'd2, 32'h0FF, 32'h0, -1, g_rd, g_er, lat, nacc, nclr);
    check_val("lwm_rdata", g_rd, 32'h44332211);
    check_val("lwm_lat", 32'(lat), 32'd13);
    check_val("lwm_nacc", 32'(nacc), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("lwm_addr", acc_q[base_idx + i].a, 32'h0FF + 32'(i));
      check_val("lwm_size", 32'(acc_q[base_idx + i].sz), 32'd0);
    end

    // SW misaligned, bus error on the 2nd sub-access
    model(1'b1, 3'd2, 32'h101, 32'hCAFEF00D, 1, e_rd, e_er, e_nacc, e_lat);
    run_op(1'b1, 3'd2, 32'h101, 32'hCAFEF00D, 1, g_rd, g_er, lat, nacc, nclr);
    check_val("swerr_err", 32'(g_er), 32'd1);
    check_val("swerr_nacc", 32'(nacc), 32'd2);
    check_val("swerr_clr", 32'(nclr), 32'd1);
    check_val("swerr_lat", 32'(lat), 32'd8);

    // Illegal funct3
    run_op(1'b0, 3'd3, 32'h40, 32'h0, -1, g_rd, g_er, lat, nacc, nclr);
    check_val("ill_lat", 32'(lat), 32'd1);
    check_val("ill_err", 32'(g_er), 32'd1);
    check_val("ill_nacc", 32'(nacc), 32'd0);

    // clear_i while waiting on memory
    ws_min = 6; ws_max = 6;
    base_idx = acc_q.size();
    req = 1'b1; write = 1'b0; f3 = 3'd2; addr = 32'h100;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("clr_busy_before", 32'(mem.mem_busy_i), 32'd1);
    clear = 1'b1;
    #1 check_val("clr_mem_clear", 32'(mem.mem_clear_o), 32'd1);
    @(negedge clk);
    clear = 1'b0;
    check_val("clr_ready", 32'(ready), 32'd1);
    check_val("clr_busy_after", 32'(mem.mem_busy_i), 32'd0);
    begin
      int ndone = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check_val("clr_no_done", 32'(ndone), 32'd0);
    end
    ws_min = 0; ws_max = 0;

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      logic        w;
      logic [2:0]  f;
      logic [31:0] a, d;
      int          rf, ws;
      w = 1'($urandom);
      f = ($urandom_range(9, 0) == 0) ? 3'($urandom) :
          (w ? 3'($urandom_range(2, 0)) : 3'($urandom_range(5, 0)));
      if (!w && f == 3'd3) f = 3'd4;
      a  = ($urandom_range(3, 0) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(3, 0))) : $urandom;
      d  = $urandom;
      rf = ($urandom_range(7, 0) == 0) ? $urandom_range(3, 0) : -1;
      ws = $urandom_range(2, 0);
      ws_min = 0; ws_max = ws;
      model(w, f, a, d, rf, e_rd, e_er, e_nacc, e_lat);
      run_op(w, f, a, d, rf, g_rd, g_er, lat, nacc, nclr);
      check_val("rnd_err", 32'(g_er), 32'(e_er));
      check_val("rnd_nacc", 32'(nacc), 32'(e_nacc));
      if (!e_er && !w) check_val("rnd_rdata", g_rd, e_rd);
      if (ws == 0) check_val("rnd_lat", 32'(lat), 32'(e_lat));
      for (int i = 0; i < nacc && i < e_nacc; i++) begin
        int k;
        k = subs_of(f, a);
        check_val("rnd_addr", acc_q[base_idx + i].a, (k == 1) ? a : a + 32'(i));
        check_val("rnd_size", 32'(acc_q[base_idx + i].sz), (k == 1) ? 32'(f[1:0]) : 32'd0);
      end
    end

    begin
      int mism = 0;
      for (int i = 0; i < 4096; i++) if (slave_mem[i] !== ref_mem[i]) mism++;
      check_val("mem_image", 32'(mism), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
